fetch_line_buffer: RTL and testbench

FETCH_LINE_BUFFER -- requirements
Module: fetch_line_buffer

---
 rtl/fetch_line_buffer_pkg.sv | 23 ++
 rtl/fetch_line_buffer.sv | 142 ++++++++++++++
 tb/tb_fetch_line_buffer.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_line_buffer_pkg.sv
// rtl/fetch_line_buffer_pkg.sv - shared system-bus constants and fetch state encoding
package fetch_line_buffer_pkg;

  localparam logic SYSBUS_READ  = 1'b1;
  localparam logic SYSBUS_WRITE = 1'b0;

  // Read command tag: bit 12 carries the read/write direction.
  localparam logic [12:0] TAG_READ = 13'h1100;

  localparam int LINE_BITS      = 512;
  localparam int BEAT_BITS      = 64;
  localparam int BEATS_PER_LINE = LINE_BITS / BEAT_BITS;
  localparam int WORDS_PER_LINE = LINE_BITS / 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_RECV,
    ST_DRAIN,
    ST_FLUSH
  } fetch_state_t;

endpackage

// File: rtl/fetch_line_buffer.sv
// rtl/fetch_line_buffer.sv - fetches one 512-bit line over the system bus and streams its instructions
module fetch_line_buffer
  import fetch_line_buffer_pkg::*;
#(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int LINE_BEATS     = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [BUS_DATA_WIDTH-1:0] start_pc,
  input  logic                      redirect,
  input  logic [BUS_DATA_WIDTH-1:0] redirect_pc,
  output logic                      bus_reqcyc,
  input  logic                      bus_reqack,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_respcyc,
  output logic                      bus_respack,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
  output logic                      instr_valid,
  input  logic                      instr_ready,
  output logic [31:0]               instr,
  output logic [BUS_DATA_WIDTH-1:0] instr_pc
);

  localparam int LINE_W = BUS_DATA_WIDTH * LINE_BEATS;
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int BEAT_W = $clog2(LINE_BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);

  fetch_state_t              state;
  logic [BUS_DATA_WIDTH-1:0] pc;
  logic [BUS_DATA_WIDTH-1:0] pending_pc;
  logic                      pending;
  logic [LINE_W-1:0]         line;
  logic [BEAT_W-1:0]         beat;

  logic in_req;
  logic in_drain;
  logic last_beat_in;
  logic unused_resptag;

  assign in_req       = (state == ST_REQ);
  assign in_drain     = (state == ST_DRAIN);
  assign last_beat_in = bus_respcyc && (beat == LAST_BEAT);
  assign unused_resptag = ^bus_resptag;

  // Every output except respack is a pure decode of registered state.
  assign bus_reqcyc  = in_req;
  assign bus_req     = in_req ? {pc[BUS_DATA_WIDTH-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign bus_reqtag  = in_req ? BUS_TAG_WIDTH'(TAG_READ) : '0;
  assign bus_respack = ((state == ST_RECV) || (state == ST_FLUSH)) && bus_respcyc;
  assign instr_valid = in_drain;
  assign instr       = in_drain ? line[{pc[OFF_W-1:2], 5'd0} +: 32] : '0;
  assign instr_pc    = in_drain ? pc : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      pc         <= '0;
      pending_pc <= '0;
      pending    <= 1'b0;
      line       <= '0;
      beat       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (redirect) begin
            pc    <= redirect_pc;
            state <= ST_REQ;
          end else if (start) begin
            pc    <= start_pc;
            state <= ST_REQ;
          end
        end

        ST_REQ: begin
          // The request in flight stays untouched; a redirect only arms the flush.
          if (redirect) begin
            pending_pc <= redirect_pc;
            pending    <= 1'b1;
          end
          if (bus_reqack) begin
            beat  <= '0;
            state <= (redirect || pending) ? ST_FLUSH : ST_RECV;
          end
        end

        ST_RECV: begin
          if (bus_respcyc) begin
            line[beat*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] <= bus_resp;
            beat <= beat + 1'b1;
          end
          if (redirect) begin
            // A redirect on the final beat has nothing left to flush.
            if (last_beat_in) begin
              pc    <= redirect_pc;
              beat  <= '0;
              state <= ST_REQ;
            end else begin
              pending_pc <= redirect_pc;
              pending    <= 1'b1;
              state      <= ST_FLUSH;
            end
          end else if (last_beat_in) begin
            beat  <= '0;
            state <= ST_DRAIN;
          end
        end

        ST_DRAIN: begin
          if (redirect) begin
            pc    <= redirect_pc;
            state <= ST_REQ;
          end else if (instr_ready) begin
            pc <= pc + BUS_DATA_WIDTH'(4);
            if (&pc[OFF_W-1:2]) state <= ST_REQ;
          end
        end

        ST_FLUSH: begin
          if (redirect) pending_pc <= redirect_pc;
          if (bus_respcyc) begin
            beat <= beat + 1'b1;
            if (beat == LAST_BEAT) begin
              pc      <= redirect ? redirect_pc : pending_pc;
              pending <= 1'b0;
              beat    <= '0;
              state   <= ST_REQ;
            end
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_line_buffer.sv
// tb/tb_fetch_line_buffer.sv - directed and randomized self-checking bench for fetch_line_buffer
module tb_fetch_line_buffer;

  localparam logic [12:0] EXP_TAG = 13'h1100;
  localparam int NBEATS = 8;

  logic        clk;
  logic        reset;
  logic        start;
  logic [63:0] start_pc;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        bus_reqcyc;
  logic        bus_reqack;
  logic [63:0] bus_req;
  logic [12:0] bus_reqtag;
  logic        bus_respcyc;
  logic        bus_respack;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [63:0] instr_pc;

  fetch_line_buffer dut (
    .clk(clk), .reset(reset), .start(start), .start_pc(start_pc),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .bus_reqcyc(bus_reqcyc), .bus_reqack(bus_reqack), .bus_req(bus_req),
    .bus_reqtag(bus_reqtag), .bus_respcyc(bus_respcyc), .bus_respack(bus_respack),
    .bus_resp(bus_resp), .bus_resptag(bus_resptag),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Stimulus knobs
  int ack_delay, resp_pct, ready_pct;
  bit hashed;
  logic [31:0] salt;
  bit do_start, do_redirect;
  logic [63:0] do_start_pc, do_redirect_pc;

  // Reference model and bus-slave bookkeeping
  logic [63:0] exp_pc;
  bit exp_valid, running, live, req_open, stalled_prev;
  logic [63:0] req_addr_held, beat_line, prev_pc;
  logic [31:0] prev_instr;
  int req_wait, beats_left, beat_idx, beats_total, instr_count, valid_cycles;
  logic [63:0] req_log[$];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory image: word at byte address a.
  function automatic logic [31:0] word_of(logic [63:0] a);
    if (!hashed) return {28'd0, a[5:2]};
    return ((a[31:0] ^ a[63:32]) * 32'h9E3779B1) ^ salt;
  endfunction

  function automatic logic [63:0] beat_data(logic [63:0] l, int k);
    logic [63:0] a;
    a = l + 64'(8 * k);
    return {word_of(a + 64'd4), word_of(a)};
  endfunction

  function automatic logic [63:0] line_of(logic [63:0] a);
    return {a[63:6], 6'd0};
  endfunction

  task automatic clear_model();
    exp_pc = '0; exp_valid = 0; running = 0; live = 0; req_open = 0; stalled_prev = 0;
    req_wait = 0; beats_left = 0; beat_idx = 0; beats_total = 0;
    instr_count = 0; valid_cycles = 0; req_log.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1; start = 0; redirect = 0; bus_reqack = 0; bus_respcyc = 0; instr_ready = 0;
    @(negedge clk);
    chk("rst_reqcyc", bus_reqcyc, 0);
    chk("rst_req", bus_req, 0);
    chk("rst_reqtag", bus_reqtag, 0);
    chk("rst_respack", bus_respack, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);
    reset = 0;
    clear_model();
  endtask

  // One clock: observe, drive inputs, then advance the model across the edge.
  task automatic cycle();
    bit hs, last_beat;
    @(negedge clk);
    chk("instr_valid", instr_valid, exp_valid);
    if (instr_valid) begin
      valid_cycles++;
      chk("instr_pc", instr_pc, exp_pc);
      chk("instr", instr, word_of(exp_pc));
    end
    if (stalled_prev) begin
      chk("stall_pc", instr_pc, prev_pc);
      chk("stall_instr", instr, prev_instr);
    end
    if (bus_reqcyc) begin
      chk("req_while_busy", beats_left, 0);
      if (!req_open) begin
        req_open = 1; req_wait = 0; live = 1;
        req_addr_held = bus_req;
        req_log.push_back(bus_req);
        chk("req_addr", bus_req, line_of(exp_pc));
        chk("req_tag", bus_reqtag, EXP_TAG);
      end else begin
        chk("req_hold", bus_req, req_addr_held);
      end
    end
    bus_reqack  = bus_reqcyc && req_open && (req_wait >= ack_delay);
    if (bus_reqcyc) req_wait++;
    bus_respcyc = (beats_left > 0) && ($urandom_range(99) < resp_pct);
    bus_resp    = bus_respcyc ? beat_data(beat_line, beat_idx) : {$urandom, $urandom};
    bus_resptag = 13'($urandom);
    instr_ready = ($urandom_range(99) < ready_pct);
    redirect    = do_redirect;
    redirect_pc = do_redirect ? do_redirect_pc : {$urandom, $urandom};
    start       = do_start;
    start_pc    = do_start ? do_start_pc : {$urandom, $urandom};
    #1;
    chk("respack", bus_respack, bus_respcyc);
    hs = instr_valid && instr_ready;
    if (hs) begin
      instr_count++;
      if (exp_pc[5:2] == 4'hF) exp_valid = 0;
      exp_pc = exp_pc + 64'd4;
    end
    last_beat = bus_respcyc && (beats_left == 1);
    if (bus_respcyc) begin beats_left--; beat_idx++; beats_total++; end
    if (bus_reqack) begin
      req_open = 0; beats_left = NBEATS; beat_idx = 0; beat_line = req_addr_held;
    end
    if (last_beat && live && !redirect) exp_valid = 1;
    if (redirect) begin
      exp_pc = redirect_pc; exp_valid = 0; live = 0; running = 1;
    end else if (start && !running) begin
      exp_pc = start_pc; running = 1;
    end
    stalled_prev = instr_valid && !instr_ready && !redirect;
    prev_pc = instr_pc; prev_instr = instr;
    do_redirect = 0; do_start = 0;
  endtask

  task automatic kick(logic [63:0] pc);
    do_start = 1; do_start_pc = pc;
    cycle();
  endtask

  task automatic run_reqs(int n, int budget);
    for (int i = 0; i < budget && req_log.size() < n; i++) cycle();
    chk("reqs_seen", req_log.size(), n);
  endtask

  task automatic run_beats(int n, int budget);
    for (int i = 0; i < budget && beats_total < n; i++) cycle();
    chk("beats_seen", beats_total, n);
  endtask

  initial begin
    logic [63:0] pc_hold, rpc;
    logic [31:0] instr_hold;
    reset = 1; start = 0; start_pc = 0; redirect = 0; redirect_pc = 0;
    bus_reqack = 0; bus_respcyc = 0; bus_resp = 0; bus_resptag = 0; instr_ready = 0;
    do_start = 0; do_redirect = 0; do_start_pc = 0; do_redirect_pc = 0;
    hashed = 0; salt = $urandom; ack_delay = 2; resp_pct = 100; ready_pct = 100;
    clear_model();

    // Sequential line fetch with ack after two cycles
    do_reset();
    kick(64'h1000);
    cycle();
    chk("start_latency", req_log.size(), 1);
    run_reqs(2, 200);
    chk("t1_req0", req_log[0], 64'h1000);
    chk("t1_req1", req_log[1], 64'h1040);
    chk("t1_count", instr_count, 16);

    // Unaligned start: only the last two words of the line
    do_reset();
    kick(64'h2038);
    run_reqs(2, 200);
    chk("t2_req0", req_log[0], 64'h2000);
    chk("t2_req1", req_log[1], 64'h2040);
    chk("t2_count", instr_count, 2);

    // Consumer stall for five cycles
    do_reset();
    ready_pct = 0;
    kick(64'h1000);
    for (int i = 0; i < 200 && !exp_valid; i++) cycle();
    chk("t3_valid", exp_valid, 1);
    cycle();
    pc_hold = instr_pc; instr_hold = instr;
    for (int i = 0; i < 5; i++) cycle();
    chk("t3_pc", instr_pc, pc_hold);
    chk("t3_instr", instr, instr_hold);
    chk("t3_count", instr_count, 0);
    ready_pct = 100;

    // Redirect after the third beat
    do_reset();
    ack_delay = 0;
    kick(64'h1000);
    run_beats(3, 200);
    do_redirect = 1; do_redirect_pc = 64'h3000;
    cycle();
    run_reqs(2, 200);
    chk("t4_req1", req_log[1], 64'h3000);
    chk("t4_beats", beats_total, 8);
    chk("t4_novalid", valid_cycles, 0);
    run_reqs(3, 200);
    chk("t4_count", instr_count, 16);

    // Redirect while the request is still unacknowledged
    do_reset();
    ack_delay = 4;
    kick(64'h1000);
    cycle();
    do_redirect = 1; do_redirect_pc = 64'h4000;
    cycle();
    run_reqs(2, 300);
    chk("t5_req0", req_log[0], 64'h1000);
    chk("t5_req1", req_log[1], 64'h4000);
    chk("t5_beats", beats_total, 8);
    chk("t5_novalid", valid_cycles, 0);

    // Reset in the middle of a line, then a clean fetch
    do_reset();
    ack_delay = 1;
    kick(64'h1000);
    run_beats(3, 200);
    do_reset();
    kick(64'h5000);
    run_reqs(2, 200);
    chk("t6_req0", req_log[0], 64'h5000);
    chk("t6_req1", req_log[1], 64'h5040);
    chk("t6_count", instr_count, 16);

    // Address wrap at the top of the address space
    do_reset();
    hashed = 1;
    kick(64'hFFFF_FFFF_FFFF_FFF8);
    run_reqs(2, 200);
    chk("wrap_req0", req_log[0], 64'hFFFF_FFFF_FFFF_FFC0);
    chk("wrap_req1", req_log[1], 64'h0);
    chk("wrap_count", instr_count, 2);

    // Randomized traffic with redirects
    do_reset();
    resp_pct = 70; ready_pct = 60;
    kick({$urandom, $urandom[31:2], 2'b00});
    for (int i = 0; i < 4000; i++) begin
      ack_delay = $urandom_range(3);
      if ($urandom_range(99) < 3) begin
        rpc = {$urandom, $urandom};
        if ($urandom_range(3) == 0) rpc[63:8] = '1;
        rpc[1:0] = 2'b00;
        do_redirect = 1; do_redirect_pc = rpc;
      end
      cycle();
    end
    n_cmp++;
    assert (instr_count > 100) else begin
      n_bad++;
      $error("FAIL rand_progress: observed %0d expected >100", instr_count);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
